// File: rtl/alu_op_sequencer_if.sv
// Handshake and operand/result bundle between an issuer, the sequencer and the ALU.
// slave  : sequencer side (takes commands, drives ALU operands and responses).
// master : issuer/consumer side (drives commands, accepts responses, drives ALU results).
interface alu_op_sequencer_if #(
    parameter int unsigned TAG_W = 4
);
    // command channel
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_sel;
    logic [15:0]      cmd_opa;
    logic [15:0]      cmd_opb;
    logic             cmd_cin;
    logic [TAG_W-1:0] cmd_tag;

    // ALU operand buses
    logic [1:0]       alu_sel;
    logic [15:0]      alu_a;
    logic [15:0]      alu_b;
    logic             alu_cin;
    logic [15:0]      alu_p;
    logic [15:0]      alu_q;
    logic [15:0]      alu_ma;
    logic [15:0]      alu_mb;
    logic [15:0]      alu_s;
    logic [15:0]      alu_t;

    // ALU result buses
    logic [16:0]      alu_sum;
    logic [15:0]      alu_diff;
    logic [31:0]      alu_m;
    logic [15:0]      alu_y1;
    logic [15:0]      alu_y2;

    // response channel
    logic             rsp_valid;
    logic             rsp_ready;
    logic [31:0]      rsp_data;
    logic [1:0]       rsp_sel;
    logic [TAG_W-1:0] rsp_tag;

    modport slave (
        input  cmd_valid, cmd_sel, cmd_opa, cmd_opb, cmd_cin, cmd_tag,
        input  alu_sum, alu_diff, alu_m, alu_y1, alu_y2,
        input  rsp_ready,
        output cmd_ready,
        output alu_sel, alu_a, alu_b, alu_cin, alu_p, alu_q, alu_ma, alu_mb, alu_s, alu_t,
        output rsp_valid, rsp_data, rsp_sel, rsp_tag
    );

    modport master (
        output cmd_valid, cmd_sel, cmd_opa, cmd_opb, cmd_cin, cmd_tag,
        output alu_sum, alu_diff, alu_m, alu_y1, alu_y2,
        output rsp_ready,
        input  cmd_ready,
        input  alu_sel, alu_a, alu_b, alu_cin, alu_p, alu_q, alu_ma, alu_mb, alu_s, alu_t,
        input  rsp_valid, rsp_data, rsp_sel, rsp_tag
    );
endinterface

// File: rtl/alu_op_sequencer.sv
// Issue stage for the 16-bit reversible ALU: accepts one command, drives the
// selected operand pair (all other buses zero), waits SETTLE_CYCLES for the
// datapath to settle, captures the selected result and returns it.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset
//   bus  - alu_op_sequencer_if.slave: cmd_* handshake in, alu_* operands out,
//          alu results in, rsp_* handshake out
module alu_op_sequencer #(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned TAG_W         = 4
) (
    input  logic              clk,
    input  logic              rst,
    alu_op_sequencer_if.slave bus
);

    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        RESP   = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             cmd_ready_q, cmd_ready_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [1:0]       alu_sel_q, alu_sel_d;
    logic [15:0]      alu_a_q, alu_a_d;
    logic [15:0]      alu_b_q, alu_b_d;
    logic             alu_cin_q, alu_cin_d;
    logic [15:0]      alu_p_q, alu_p_d;
    logic [15:0]      alu_q_q, alu_q_d;
    logic [15:0]      alu_ma_q, alu_ma_d;
    logic [15:0]      alu_mb_q, alu_mb_d;
    logic [15:0]      alu_s_q, alu_s_d;
    logic [15:0]      alu_t_q, alu_t_d;
    logic [31:0]      rsp_data_q, rsp_data_d;
    logic [1:0]       rsp_sel_q, rsp_sel_d;
    logic [TAG_W-1:0] rsp_tag_q, rsp_tag_d;

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            alu_sel_q   <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_cin_q   <= 1'b0;
            alu_p_q     <= '0;
            alu_q_q     <= '0;
            alu_ma_q    <= '0;
            alu_mb_q    <= '0;
            alu_s_q     <= '0;
            alu_t_q     <= '0;
            rsp_data_q  <= '0;
            rsp_sel_q   <= '0;
            rsp_tag_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            alu_sel_q   <= alu_sel_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_cin_q   <= alu_cin_d;
            alu_p_q     <= alu_p_d;
            alu_q_q     <= alu_q_d;
            alu_ma_q    <= alu_ma_d;
            alu_mb_q    <= alu_mb_d;
            alu_s_q     <= alu_s_d;
            alu_t_q     <= alu_t_d;
            rsp_data_q  <= rsp_data_d;
            rsp_sel_q   <= rsp_sel_d;
            rsp_tag_q   <= rsp_tag_d;
        end
    end

    // Next-state, operand load and result capture
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        alu_sel_d  = alu_sel_q;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        alu_cin_d  = alu_cin_q;
        alu_p_d    = alu_p_q;
        alu_q_d    = alu_q_q;
        alu_ma_d   = alu_ma_q;
        alu_mb_d   = alu_mb_q;
        alu_s_d    = alu_s_q;
        alu_t_d    = alu_t_q;
        rsp_data_d = rsp_data_q;
        rsp_sel_d  = rsp_sel_q;
        rsp_tag_d  = rsp_tag_q;

        case (state_q)
            IDLE: begin
                // cmd_ready_q is low for the first cycle out of reset
                if (bus.cmd_valid && cmd_ready_q) begin
                    alu_sel_d = bus.cmd_sel;
                    rsp_sel_d = bus.cmd_sel;
                    rsp_tag_d = bus.cmd_tag;
                    alu_a_d   = '0;
                    alu_b_d   = '0;
                    alu_cin_d = 1'b0;
                    alu_p_d   = '0;
                    alu_q_d   = '0;
                    alu_ma_d  = '0;
                    alu_mb_d  = '0;
                    alu_s_d   = '0;
                    alu_t_d   = '0;
                    case (bus.cmd_sel)
                        2'd0: begin
                            alu_a_d   = bus.cmd_opa;
                            alu_b_d   = bus.cmd_opb;
                            alu_cin_d = bus.cmd_cin;
                        end
                        2'd1: begin
                            alu_p_d = bus.cmd_opa;
                            alu_q_d = bus.cmd_opb;
                        end
                        2'd2: begin
                            alu_ma_d = bus.cmd_opa;
                            alu_mb_d = bus.cmd_opb;
                        end
                        default: begin
                            alu_s_d = bus.cmd_opa;
                            alu_t_d = bus.cmd_opb;
                        end
                    endcase
                    cnt_d   = CNT_W'(SETTLE_CYCLES - 1);
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                if (cnt_q == '0) begin
                    case (alu_sel_q)
                        2'd0:    rsp_data_d = {15'b0, bus.alu_sum};
                        2'd1:    rsp_data_d = {16'b0, bus.alu_diff};
                        2'd2:    rsp_data_d = bus.alu_m;
                        default: rsp_data_d = {bus.alu_y2, bus.alu_y1};
                    endcase
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP: begin
                if (rsp_valid_q && bus.rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Handshake flags follow the state being entered
        cmd_ready_d = (state_d == IDLE);
        rsp_valid_d = (state_d == RESP);
    end

    assign bus.cmd_ready = cmd_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_sel   = rsp_sel_q;
    assign bus.rsp_tag   = rsp_tag_q;
    assign bus.alu_sel   = alu_sel_q;
    assign bus.alu_a     = alu_a_q;
    assign bus.alu_b     = alu_b_q;
    assign bus.alu_cin   = alu_cin_q;
    assign bus.alu_p     = alu_p_q;
    assign bus.alu_q     = alu_q_q;
    assign bus.alu_ma    = alu_ma_q;
    assign bus.alu_mb    = alu_mb_q;
    assign bus.alu_s     = alu_s_q;
    assign bus.alu_t     = alu_t_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer: dut_a (SETTLE_CYCLES=2) carries the
// directed and random traffic, dut_b (SETTLE_CYCLES=4) the longer settle case.
module tb_alu_op_sequencer;

    localparam int unsigned SETTLE_A = 2;
    localparam int unsigned SETTLE_B = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_err = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_op_sequencer_if #(.TAG_W(4)) ifa ();
    alu_op_sequencer_if #(.TAG_W(4)) ifb ();

    alu_op_sequencer #(.SETTLE_CYCLES(SETTLE_A), .TAG_W(4)) dut_a (
        .clk(clk), .rst(rst), .bus(ifa)
    );
    alu_op_sequencer #(.SETTLE_CYCLES(SETTLE_B), .TAG_W(4)) dut_b (
        .clk(clk), .rst(rst), .bus(ifb)
    );

    // ALU stubs
    assign ifa.alu_sum  = 17'(ifa.alu_a) + 17'(ifa.alu_b) + 17'(ifa.alu_cin);
    assign ifa.alu_diff = ifa.alu_p - ifa.alu_q;
    assign ifa.alu_m    = 32'(ifa.alu_ma) * 32'(ifa.alu_mb);
    assign ifa.alu_y1   = ifa.alu_s << ifa.alu_t;
    assign ifa.alu_y2   = ifa.alu_s >> ifa.alu_t;
    assign ifb.alu_sum  = 17'(ifb.alu_a) + 17'(ifb.alu_b) + 17'(ifb.alu_cin);
    assign ifb.alu_diff = ifb.alu_p - ifb.alu_q;
    assign ifb.alu_m    = 32'(ifb.alu_ma) * 32'(ifb.alu_mb);
    assign ifb.alu_y1   = ifb.alu_s << ifb.alu_t;
    assign ifb.alu_y2   = ifb.alu_s >> ifb.alu_t;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  sel;
        logic [3:0]  tag;
        int          acc;
    } exp_t;

    exp_t exp_q[$];
    logic busy_a = 1'b0;
    logic seen_valid = 1'b0;
    logic expect_idle = 1'b0;
    int   cur_sel, cur_opa, cur_opb, cur_cin;
    int   bp_mode = 0;          // 0: always ready, 1: random, 2: hold low
    logic rsp_ready_a = 1'b1;

    assign ifa.rsp_ready = rsp_ready_a;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string nm);
        n_checks++;
        n_err++;
        $display("FAIL %s (t=%0t)", nm, $time);
    endtask

    // Reference: the packed response word from the operands alone
    function automatic logic [31:0] model(input int sel, input int a, input int b, input int cin);
        longint unsigned la, lb, lc, r;
        la = longint'(a);
        lb = longint'(b);
        lc = longint'(cin);
        case (sel)
            0:       r = la + lb + lc;
            1:       r = (la - lb) & 64'hFFFF;
            2:       r = la * lb;
            default: r = (((la >> lb) & 64'hFFFF) << 16) | ((la << lb) & 64'hFFFF);
        endcase
        return 32'(r);
    endfunction

    // Response backpressure generator for dut_a
    always @(posedge clk) begin
        #1;
        case (bp_mode)
            0:       rsp_ready_a = 1'b1;
            1:       rsp_ready_a = 1'($urandom_range(0, 1));
            default: rsp_ready_a = 1'b0;
        endcase
    end

    // Monitor / scoreboard for dut_a
    always @(negedge clk) begin
        if (!rst) begin
            if (expect_idle) begin
                chk("ready_after_hs", 32'(ifa.cmd_ready), 32'd1);
                chk("valid_after_hs", 32'(ifa.rsp_valid), 32'd0);
                expect_idle = 1'b0;
            end
            if (busy_a) begin
                logic [15:0] ea, eb, ep, eq, ema, emb, es, et;
                logic ecin;
                {ea, eb, ep, eq, ema, emb, es, et} = '0;
                ecin = 1'b0;
                case (cur_sel)
                    0: begin ea = 16'(cur_opa); eb = 16'(cur_opb); ecin = 1'(cur_cin); end
                    1: begin ep = 16'(cur_opa); eq = 16'(cur_opb); end
                    2: begin ema = 16'(cur_opa); emb = 16'(cur_opb); end
                    default: begin es = 16'(cur_opa); et = 16'(cur_opb); end
                endcase
                chk("busy_cmd_ready", 32'(ifa.cmd_ready), 32'd0);
                chk("alu_sel", 32'(ifa.alu_sel), 32'(cur_sel));
                chk("alu_a", 32'(ifa.alu_a), 32'(ea));
                chk("alu_b", 32'(ifa.alu_b), 32'(eb));
                chk("alu_cin", 32'(ifa.alu_cin), 32'(ecin));
                chk("alu_p", 32'(ifa.alu_p), 32'(ep));
                chk("alu_q", 32'(ifa.alu_q), 32'(eq));
                chk("alu_ma", 32'(ifa.alu_ma), 32'(ema));
                chk("alu_mb", 32'(ifa.alu_mb), 32'(emb));
                chk("alu_s", 32'(ifa.alu_s), 32'(es));
                chk("alu_t", 32'(ifa.alu_t), 32'(et));
            end
            if (ifa.rsp_valid) begin
                if (exp_q.size() == 0) begin
                    fail_now("spurious_rsp");
                end else begin
                    exp_t e;
                    e = exp_q[0];
                    if (!seen_valid) begin
                        seen_valid = 1'b1;
                        chk("latency", 32'(cyc - e.acc), 32'(SETTLE_A));
                    end
                    chk("rsp_data", ifa.rsp_data, e.data);
                    chk("rsp_sel", 32'(ifa.rsp_sel), 32'(e.sel));
                    chk("rsp_tag", 32'(ifa.rsp_tag), 32'(e.tag));
                    if (ifa.rsp_ready) begin
                        void'(exp_q.pop_front());
                        seen_valid  = 1'b0;
                        busy_a      = 1'b0;
                        expect_idle = 1'b1;
                    end
                end
            end
        end
    end

    task automatic issue_a(input int sel, input int a, input int b, input int cin, input int tag);
        int n;
        n = 0;
        @(negedge clk);
        while (!ifa.cmd_ready) begin
            n++;
            if (n > 200) begin
                fail_now("issue_timeout");
                return;
            end
            @(negedge clk);
        end
        ifa.cmd_valid = 1'b1;
        ifa.cmd_sel   = 2'(sel);
        ifa.cmd_opa   = 16'(a);
        ifa.cmd_opb   = 16'(b);
        ifa.cmd_cin   = 1'(cin);
        ifa.cmd_tag   = 4'(tag);
        @(posedge clk);
        #1;
        // garbage on the idle command bus must be ignored
        ifa.cmd_valid = 1'b0;
        ifa.cmd_sel   = 2'($urandom);
        ifa.cmd_opa   = 16'($urandom);
        ifa.cmd_opb   = 16'($urandom);
        ifa.cmd_cin   = 1'($urandom);
        cur_sel = sel;
        cur_opa = a;
        cur_opb = b;
        cur_cin = cin;
        busy_a  = 1'b1;
        exp_q.push_back('{model(sel, a, b, cin), 2'(sel), 4'(tag), cyc});
    endtask

    task automatic drain_a();
        int n;
        n = 0;
        while (exp_q.size() != 0 || busy_a || expect_idle) begin
            n++;
            if (n > 300) begin
                fail_now("drain_timeout");
                exp_q.delete();
                busy_a = 1'b0;
                return;
            end
            @(negedge clk);
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        rst = 1'b1;
        ifa.cmd_valid = 1'b0;
        ifb.cmd_valid = 1'b0;
        exp_q.delete();
        busy_a      = 1'b0;
        seen_valid  = 1'b0;
        expect_idle = 1'b0;
        @(negedge clk);
        chk("rst_cmd_ready", 32'(ifa.cmd_ready), 32'd0);
        chk("rst_rsp_valid", 32'(ifa.rsp_valid), 32'd0);
        chk("rst_rsp_data", ifa.rsp_data, 32'd0);
        chk("rst_rsp_sel_tag", 32'({ifa.rsp_sel, ifa.rsp_tag}), 32'd0);
        chk("rst_alu_sel_cin", 32'({ifa.alu_sel, ifa.alu_cin}), 32'd0);
        chk("rst_alu_ab", {ifa.alu_a, ifa.alu_b}, 32'd0);
        chk("rst_alu_pq", {ifa.alu_p, ifa.alu_q}, 32'd0);
        chk("rst_alu_m", {ifa.alu_ma, ifa.alu_mb}, 32'd0);
        chk("rst_alu_st", {ifa.alu_s, ifa.alu_t}, 32'd0);
        chk("rst_b_outs", 32'({ifb.cmd_ready, ifb.rsp_valid}) | ifb.rsp_data | 32'(ifb.alu_a), 32'd0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("ready_after_rst", 32'(ifa.cmd_ready), 32'd1);
        chk("b_ready_after_rst", 32'(ifb.cmd_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int got;
        int accb;
        ifa.cmd_valid = 1'b0; ifa.cmd_sel = '0; ifa.cmd_opa = '0; ifa.cmd_opb = '0;
        ifa.cmd_cin = 1'b0; ifa.cmd_tag = '0;
        ifb.cmd_valid = 1'b0; ifb.cmd_sel = '0; ifb.cmd_opa = '0; ifb.cmd_opb = '0;
        ifb.cmd_cin = 1'b0; ifb.cmd_tag = '0; ifb.rsp_ready = 1'b0;

        do_reset();

        // add, then back-to-back sub and mul
        issue_a(0, 340, 45, 1, 1);
        issue_a(1, 450, 30, 0, 5);
        issue_a(2, 342, 56, 0, 2);
        drain_a();

        // op3 under backpressure
        bp_mode = 2;
        issue_a(3, 234, 3, 0, 7);
        got = 0;
        for (int k = 0; k < 20 && got == 0; k++) begin
            @(negedge clk);
            if (ifa.rsp_valid) got = 1;
        end
        if (got == 0) fail_now("op3_no_rsp");
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("op3_held_valid", 32'(ifa.rsp_valid), 32'd1);
            chk("op3_held_data", ifa.rsp_data, 32'h001D0750);
        end
        bp_mode = 0;
        drain_a();

        // random traffic with random backpressure
        bp_mode = 1;
        for (int i = 0; i < 60; i++) begin
            int s;
            s = int'($urandom_range(0, 3));
            issue_a(s, int'($urandom_range(0, 65535)),
                    (s == 3) ? int'($urandom_range(0, 17)) : int'($urandom_range(0, 65535)),
                    int'($urandom_range(0, 1)), int'($urandom_range(0, 15)));
        end
        bp_mode = 0;
        drain_a();

        // reset while a multiply is settling
        issue_a(2, 1234, 5678, 0, 3);
        do_reset();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("no_rsp_after_rst", 32'(ifa.rsp_valid), 32'd0);
        end
        issue_a(0, 1, 1, 0, 9);
        drain_a();

        // longer settle on dut_b; command bus scrambled while it settles
        got = 0;
        for (int k = 0; k < 20 && !ifb.cmd_ready; k++) @(negedge clk);
        ifb.cmd_valid = 1'b1;
        ifb.cmd_sel   = 2'd0;
        ifb.cmd_opa   = 16'd678;
        ifb.cmd_opb   = 16'd32;
        ifb.cmd_cin   = 1'b1;
        ifb.cmd_tag   = 4'hA;
        @(posedge clk);
        #1;
        accb = cyc;
        for (int k = 0; k < 12 && got == 0; k++) begin
            ifb.cmd_opa = 16'($urandom);
            ifb.cmd_opb = 16'($urandom);
            ifb.cmd_sel = 2'($urandom);
            @(negedge clk);
            chk("b_alu_a", 32'(ifb.alu_a), 32'd678);
            chk("b_alu_b", 32'(ifb.alu_b), 32'd32);
            chk("b_alu_sel", 32'(ifb.alu_sel), 32'd0);
            chk("b_cmd_ready", 32'(ifb.cmd_ready), 32'd0);
            if (ifb.rsp_valid) begin
                got = 1;
                chk("b_latency", 32'(cyc - accb), 32'(SETTLE_B));
                chk("b_data", ifb.rsp_data, 32'd711);
                chk("b_tag", 32'(ifb.rsp_tag), 32'hA);
            end
        end
        if (got == 0) fail_now("b_no_rsp");
        ifb.cmd_valid = 1'b0;
        ifb.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        ifb.rsp_ready = 1'b0;
        @(negedge clk);
        chk("b_ready_after_hs", 32'(ifb.cmd_ready), 32'd1);
        chk("b_valid_after_hs", 32'(ifb.rsp_valid), 32'd0);

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
